// File: rtl/hc_pkg.sv
// Shared types and constants for the hybrid-controller gate-drive path.
package hc_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    DEAD_P = 3'd1,
    POS    = 3'd2,
    DEAD_N = 3'd3,
    NEG    = 3'd4,
    FAULT  = 3'd5
  } state_e;

  localparam logic [3:0] GATE_OFF = 4'b0000;
  localparam logic [3:0] GATE_POS = 4'b1001;
  localparam logic [3:0] GATE_NEG = 4'b0110;

  function automatic logic [3:0] gate_of(input state_e s);
    case (s)
      POS:     gate_of = GATE_POS;
      NEG:     gate_of = GATE_NEG;
      default: gate_of = GATE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/period_meter.sv
// Measures cycles between successive starts; the first start after disarm only arms.
module period_meter #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                i_clock,
  input  logic                i_RESET,
  input  logic                i_start,
  input  logic                i_disarm,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_valid
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                armed_q, armed_d;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    armed_d  = armed_q;
    if (i_start) begin
      cnt_d   = PERIOD_W'(1);
      armed_d = 1'b1;
      if (armed_q) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end
    end else begin
      // Saturating count: a stalled switcher reads as all-ones, never a wrapped small value.
      if (cnt_q != '1) cnt_d = cnt_q + PERIOD_W'(1);
      if (i_disarm) armed_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      armed_q  <= armed_d;
    end
  end

  assign o_period = period_q;
  assign o_valid  = valid_q;

endmodule

// File: rtl/deadtime_gate_driver.sv
// Full-bridge gate sequencer: sigma to four gate drives with dead time, enable and latched fault.
module deadtime_gate_driver
  import hc_pkg::*;
#(
  parameter int unsigned DEADTIME = 10,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                i_clock,
  input  logic                i_RESET,
  input  logic                i_sigma,
  input  logic                i_enable,
  input  logic                i_fault,
  input  logic                i_clear,
  output logic [3:0]          o_MOSFET,
  output logic [2:0]          o_state,
  output logic                o_fault,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_period_valid
);

  localparam int unsigned CNT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gate_q;
  logic             fault_q;
  logic             meter_start, meter_disarm;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_fault) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        FAULT: if (i_clear) state_d = OFF;
        OFF: begin
          if (i_enable) begin
            state_d = i_sigma ? DEAD_P : DEAD_N;
            cnt_d   = CNT_LOAD;
          end
        end
        POS, NEG, DEAD_P, DEAD_N: begin
          if (!i_enable) begin
            state_d = OFF;
          end else if (state_q == POS) begin
            if (!i_sigma) begin
              state_d = DEAD_N;
              cnt_d   = CNT_LOAD;
            end
          end else if (state_q == NEG) begin
            if (i_sigma) begin
              state_d = DEAD_P;
              cnt_d   = CNT_LOAD;
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (i_sigma == (state_q == DEAD_P)) begin
            state_d = (state_q == DEAD_P) ? POS : NEG;
          end else begin
            // Direction reversed during the dead time: restart it toward the other leg.
            state_d = (state_q == DEAD_P) ? DEAD_N : DEAD_P;
            cnt_d   = CNT_LOAD;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign meter_start  = (state_d == POS) && (state_q != POS);
  assign meter_disarm = (state_d == OFF) || (state_d == FAULT);

  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= OFF;
      cnt_q   <= '0;
      gate_q  <= GATE_OFF;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_of(state_d);
      fault_q <= (state_d == FAULT);
    end
  end

  period_meter #(
    .PERIOD_W (PERIOD_W)
  ) u_meter (
    .i_clock  (i_clock),
    .i_RESET  (i_RESET),
    .i_start  (meter_start),
    .i_disarm (meter_disarm),
    .o_period (o_period),
    .o_valid  (o_period_valid)
  );

  assign o_MOSFET = gate_q;
  assign o_state  = state_q;
  assign o_fault  = fault_q;

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Directed bench for deadtime_gate_driver: vector table plus multi-cycle sequences.
module tb_deadtime_gate_driver;

  logic        clk = 1'b0;
  logic        rst, sigma, en, flt, clr;
  logic [3:0]  gate, n_gate;
  logic [2:0]  st, n_st;
  logic        fo, n_fo, pv, n_pv;
  logic [15:0] per;
  logic [7:0]  n_per;

  int checks = 0;
  int failures = 0;
  int zrun = 0;
  logic [3:0] prev_gate = 4'b0000;
  logic       saw_neg;

  always #5 clk = ~clk;

  deadtime_gate_driver #(.DEADTIME(10), .PERIOD_W(16)) dut (
    .i_clock(clk), .i_RESET(rst), .i_sigma(sigma), .i_enable(en),
    .i_fault(flt), .i_clear(clr), .o_MOSFET(gate), .o_state(st),
    .o_fault(fo), .o_period(per), .o_period_valid(pv)
  );

  deadtime_gate_driver #(.DEADTIME(10), .PERIOD_W(8)) dut_narrow (
    .i_clock(clk), .i_RESET(rst), .i_sigma(sigma), .i_enable(en),
    .i_fault(flt), .i_clear(clr), .o_MOSFET(n_gate), .o_state(n_st),
    .o_fault(n_fo), .o_period(n_per), .o_period_valid(n_pv)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (gate == 4'b0110) saw_neg = 1'b1;
    end
  endtask

  // Shoot-through and minimum all-off gap monitor on the opposite clock edge.
  always @(negedge clk) begin
    checks++;
    if (!(gate inside {4'b0000, 4'b1001, 4'b0110}) ||
        !(n_gate inside {4'b0000, 4'b1001, 4'b0110})) begin
      failures++;
      $display("FAIL gate_legal: got=%b/%b expected one of 0000,1001,0110", gate, n_gate);
    end
    if (gate == 4'b0000) begin
      zrun++;
    end else begin
      if (prev_gate == 4'b0000) begin
        checks++;
        if (zrun < 10) begin
          failures++;
          $display("FAIL dead_gap: got=%0d off cycles expected>=10 before %b", zrun, gate);
        end
      end
      zrun = 0;
    end
    prev_gate = gate;
  end

  typedef struct {
    int         n;
    logic       sig, en, flt, clr;
    logic [2:0] st;
    logic [3:0] g;
    logic       f, v;
  } vec_t;

  vec_t tbl[20];

  task automatic run_wave(input int halfp, input int ncyc, input int exp_per,
                          input int exp_nper, input int exp_strobes);
    int entries = 0;
    int strobes = 0;
    logic [2:0] prev_st;
    logic exp_v;
    en = 1'b1;
    prev_st = st;
    for (int c = 0; c < ncyc; c++) begin
      sigma = ((c % (2 * halfp)) < halfp);
      tick(1);
      exp_v = 1'b0;
      if (st == 3'd2 && prev_st != 3'd2) begin
        entries++;
        exp_v = (entries > 1);
      end
      if (pv || exp_v) chk("period_strobe", pv, exp_v);
      if (pv) begin
        strobes++;
        chk("period_value", per, exp_per);
        chk("narrow_strobe", n_pv, 1);
        chk("narrow_period_sat", n_per, exp_nper);
      end
      prev_st = st;
    end
    chk("strobe_count", strobes, exp_strobes);
  endtask

  initial begin
    rst = 1'b1; sigma = 1'b0; en = 1'b0; flt = 1'b0; clr = 1'b0;
    #12;
    chk("rst_gate", gate, 4'b0000);
    chk("rst_state", st, 3'd0);
    chk("rst_fault", fo, 0);
    chk("rst_period", per, 0);
    chk("rst_valid", pv, 0);
    rst = 1'b0;

    //         n  sig   en    flt   clr   st    gate      f     v
    tbl[0]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{9,  1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'b1001, 1'b0, 1'b0};
    tbl[4]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{9,  1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 4'b0110, 1'b0, 1'b0};
    tbl[7]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4'b0000, 1'b1, 1'b0};
    tbl[8]  = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 4'b0000, 1'b1, 1'b0};
    tbl[9]  = '{1,  1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 4'b0000, 1'b1, 1'b0};
    tbl[10] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0};
    tbl[11] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'b1001, 1'b0, 1'b0};
    tbl[15] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
    tbl[16] = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 4'b0000, 1'b0, 1'b0};
    tbl[17] = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'b1001, 1'b0, 1'b0};
    tbl[18] = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4'b0000, 1'b1, 1'b0};
    tbl[19] = '{1,  1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      sigma = tbl[i].sig; en = tbl[i].en; flt = tbl[i].flt; clr = tbl[i].clr;
      tick(tbl[i].n);
      chk($sformatf("vec%0d_state", i), st, tbl[i].st);
      chk($sformatf("vec%0d_gate", i), gate, tbl[i].g);
      chk($sformatf("vec%0d_fault", i), fo, tbl[i].f);
      chk($sformatf("vec%0d_valid", i), pv, tbl[i].v);
    end
    clr = 1'b0;

    // Restart after FAULT -> OFF: meter re-arms, 200-cycle then 600-cycle square waves.
    run_wave(100, 1000, 200, 200, 4);
    en = 1'b0; tick(1);
    chk("wave_off", st, 3'd0);
    run_wave(300, 1300, 600, 255, 2);

    // Commutation timing POS -> NEG.
    en = 1'b0; tick(1);
    en = 1'b1; sigma = 1'b1; tick(11);
    chk("comm_pos", gate, 4'b1001);
    sigma = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("comm_dead%0d", i), {1'b0, st, gate}, {1'b0, 3'd3, 4'b0000});
    end
    tick(1);
    chk("comm_neg_gate", gate, 4'b0110);
    chk("comm_neg_state", st, 3'd4);

    // Sigma glitch inside DEAD_N reverses toward POS without ever driving NEG.
    sigma = 1'b1; tick(11);
    chk("glitch_pos0", st, 3'd2);
    saw_neg = 1'b0;
    sigma = 1'b0; tick(3);
    sigma = 1'b1; tick(7);
    chk("glitch_deadn", st, 3'd3);
    tick(1);
    chk("glitch_deadp", st, 3'd1);
    tick(9);
    chk("glitch_deadp_hold", st, 3'd1);
    tick(1);
    chk("glitch_pos", st, 3'd2);
    chk("glitch_no_neg", saw_neg, 0);

    // Asynchronous reset in the middle of DEAD_P.
    en = 1'b0; tick(1);
    en = 1'b1; sigma = 1'b1; tick(4);
    chk("pre_rst_deadp", st, 3'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_gate", gate, 4'b0000);
    chk("arst_state", st, 3'd0);
    chk("arst_period", per, 0);
    chk("arst_valid", pv, 0);
    chk("arst_narrow", {n_gate, n_st, n_fo, n_per}, 0);
    en = 1'b0;
    #3 rst = 1'b0;
    tick(3);
    chk("post_rst_off", st, 3'd0);
    en = 1'b1; tick(1);
    chk("post_rst_deadp", st, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
